// File: rtl/entropy_term_accum_if.sv
// Purpose: count stream from the popcount stage and window result bus of entropy_term_accum.
// Latency: none; wires only.
// Backpressure: none; the producer streams counts and the consumer must take every o_valid/o_err pulse.
//   slave  modport: the accumulator (takes i_cnt/i_cnt_valid, drives o_sum/o_total/o_valid/o_err)
//   master modport: the environment driving counts and consuming results
interface entropy_term_accum_if #(
    parameter int CNT_W = 9,
    parameter int ACC_W = 20,
    parameter int TOT_W = 12
);
    logic [CNT_W-1:0] i_cnt;
    logic             i_cnt_valid;
    logic [ACC_W-1:0] o_sum;
    logic [TOT_W-1:0] o_total;
    logic             o_valid;
    logic             o_err;

    modport slave (
        input  i_cnt, i_cnt_valid,
        output o_sum, o_total, o_valid, o_err
    );

    modport master (
        output i_cnt, i_cnt_valid,
        input  o_sum, o_total, o_valid, o_err
    );
endinterface

// File: rtl/entropy_term_accum.sv
// Purpose: per 8-count window, S = sum c*log2(c) (Q.4, piecewise-linear log2) and T = sum c.
// Latency: o_valid rises 3 edges after the edge sampling the 8th count; o_err 1 edge after a gap.
// Backpressure: none; fully pipelined, back-to-back windows accepted, a gap mid-window aborts it.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_cnt/i_cnt_valid in; o_sum/o_total/o_valid/o_err out
module entropy_term_accum #(
    parameter int CNT_W = 9,
    parameter int ACC_W = 20,
    parameter int TOT_W = 12,
    parameter int BURST = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    entropy_term_accum_if.slave   bus
);
    localparam int PROD_W = CNT_W + 8;

    // Fractional part of log2(1.m) in Q.4, indexed by the 4 mantissa bits below the leading one.
    localparam logic [3:0] LUT [16] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                        4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15};

    typedef enum logic [0:0] {IDLE, COLLECT} state_t;

    state_t              state_q;
    logic [2:0]          idx_q;
    logic                err_q;

    // S1: sampled count, its log2, and window tags
    logic                s1_vld_q, s1_first_q, s1_last_q;
    logic [CNT_W-1:0]    s1_c_q;
    logic [7:0]          s1_l_q;
    // S2: product c*L
    logic                s2_vld_q, s2_first_q, s2_last_q;
    logic [CNT_W-1:0]    s2_c_q;
    logic [PROD_W-1:0]   s2_prod_q;
    // ACC
    logic [ACC_W-1:0]    acc_s_q;
    logic [TOT_W-1:0]    acc_t_q;
    logic                acc_done_q;
    // OUT
    logic [ACC_W-1:0]    sum_q;
    logic [TOT_W-1:0]    total_q;
    logic                valid_q;

    logic                abort_d;
    logic [3:0]          p_d;
    logic [3:0]          sh_d;
    logic [CNT_W-1:0]    norm_d;
    logic [7:0]          l_d;
    logic [PROD_W-1:0]   prod_d;

    // A missing count while collecting kills the window.
    assign abort_d = (state_q == COLLECT) && !bus.i_cnt_valid;

    // Leading-one position, then left-justify so the mantissa sits just below the MSB;
    // this shift zero-pads the mantissa on the right for small counts.
    always_comb begin
        p_d = '0;
        for (int b = 0; b < CNT_W; b++) begin
            if (bus.i_cnt[b]) p_d = 4'(b);
        end
        sh_d   = 4'(CNT_W - 1) - p_d;
        norm_d = bus.i_cnt << sh_d;
        l_d    = (bus.i_cnt == '0) ? 8'd0 : {p_d, LUT[norm_d[CNT_W-2 -: 4]]};
    end

    assign prod_d = PROD_W'(s1_c_q) * PROD_W'(s1_l_q);

    // Window-framing FSM; also registers the S1 tags and the abort pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s1_vld_q   <= bus.i_cnt_valid;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_cnt_valid) begin
                        s1_first_q <= 1'b1;
                        idx_q      <= 3'd1;
                        state_q    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.i_cnt_valid) begin
                        if (idx_q == 3'(BURST - 1)) begin
                            s1_last_q <= 1'b1;
                            idx_q     <= '0;
                            state_q   <= IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_c_q     <= '0;
            s1_l_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_c_q     <= '0;
            s2_prod_q  <= '0;
            acc_s_q    <= '0;
            acc_t_q    <= '0;
            acc_done_q <= 1'b0;
            sum_q      <= '0;
            total_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            s1_c_q <= bus.i_cnt;
            s1_l_q <= l_d;

            // The element in S1 belongs to the aborted window; drop it before it reaches ACC.
            s2_vld_q   <= s1_vld_q && !abort_d;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_c_q     <= s1_c_q;
            s2_prod_q  <= prod_d;

            // A partial window left in the accumulator is harmless: the next first element reloads it.
            if (s2_vld_q) begin
                if (s2_first_q) begin
                    acc_s_q <= ACC_W'(s2_prod_q);
                    acc_t_q <= TOT_W'(s2_c_q);
                end else begin
                    acc_s_q <= acc_s_q + ACC_W'(s2_prod_q);
                    acc_t_q <= acc_t_q + TOT_W'(s2_c_q);
                end
            end
            acc_done_q <= s2_vld_q && s2_last_q;

            valid_q <= acc_done_q;
            if (acc_done_q) begin
                sum_q   <= acc_s_q;
                total_q <= acc_t_q;
            end
        end
    end

    assign bus.o_sum   = sum_q;
    assign bus.o_total = total_q;
    assign bus.o_valid = valid_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_entropy_term_accum.sv
module tb_entropy_term_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    entropy_term_accum_if bus ();

    entropy_term_accum dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int lut [16] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15};

    // log2(c) in Q4.4: integer part = floor(log2 c), fraction from the 4 bits below the top one.
    function automatic int log2q4(input int c);
        int p, m;
        if (c == 0) return 0;
        p = $clog2(c + 1) - 1;
        m = ((c * 16) >> p) % 16;
        return p * 16 + lut[m];
    endfunction

    int cur [$];            // counts of the window being sent
    int exp_sum [int];      // cycle -> expected o_sum on an o_valid pulse
    int exp_tot [int];
    bit exp_err [int];      // cycle -> o_err pulse expected
    int held_sum = 0;
    int held_tot = 0;

    task automatic drive(input bit v, input int c);
        int s, t;
        @(posedge clk);
        #1;
        bus.i_cnt_valid = v;
        bus.i_cnt       = 9'(c);
        if (v) begin
            cur.push_back(c);
            if (cur.size() == 8) begin
                s = 0;
                t = 0;
                foreach (cur[k]) begin
                    s += cur[k] * log2q4(cur[k]);
                    t += cur[k];
                end
                exp_sum[cyc + 4] = s;
                exp_tot[cyc + 4] = t;
                cur.delete();
            end
        end else if (cur.size() > 0) begin
            exp_err[cyc + 1] = 1'b1;
            cur.delete();
        end
    endtask

    task automatic do_reset(input int len);
        int kill [$];
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.i_cnt_valid = 1'b0;
        cur.delete();
        foreach (exp_sum[k]) if (k >= cyc) kill.push_back(k);
        foreach (kill[i]) begin
            exp_sum.delete(kill[i]);
            exp_tot.delete(kill[i]);
        end
        kill.delete();
        foreach (exp_err[k]) if (k >= cyc) kill.push_back(k);
        foreach (kill[i]) exp_err.delete(kill[i]);
        held_sum = 0;
        held_tot = 0;
        repeat (len) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_window(input int v [8]);
        for (int i = 0; i < 8; i++) drive(1'b1, v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, int'($urandom_range(0, 511)));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit ev, ee;
        ev = exp_sum.exists(cyc);
        ee = exp_err.exists(cyc);
        if (ev) begin
            held_sum = exp_sum[cyc];
            held_tot = exp_tot[cyc];
        end
        if (bus.o_valid || ev) chk("o_valid", 32'(bus.o_valid), 32'(ev));
        if (bus.o_err || ee)   chk("o_err", 32'(bus.o_err), 32'(ee));
        chk("o_sum", 32'(bus.o_sum), 32'(held_sum));
        chk("o_total", 32'(bus.o_total), 32'(held_tot));
    end

    // ---------------- stimulus ----------------
    initial begin
        int w [8];
        int r, k;
        bus.i_cnt_valid = 1'b0;
        bus.i_cnt       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // eight 256s
        w = '{256, 256, 256, 256, 256, 256, 256, 256};
        send_window(w);
        idle(6);
        chk("plan_256_sum", 32'(bus.o_sum), 32'd262144);
        chk("plan_256_tot", 32'(bus.o_total), 32'd2048);

        // eight 3s
        w = '{3, 3, 3, 3, 3, 3, 3, 3};
        send_window(w);
        idle(6);
        chk("plan_3_sum", 32'(bus.o_sum), 32'd600);
        chk("plan_3_tot", 32'(bus.o_total), 32'd24);

        // mixed with zeros and a 1
        w = '{32, 32, 0, 0, 0, 0, 0, 1};
        send_window(w);
        idle(6);
        chk("plan_mix_sum", 32'(bus.o_sum), 32'd5120);
        chk("plan_mix_tot", 32'(bus.o_total), 32'd65);

        // back-to-back: all 256 then all 1
        w = '{256, 256, 256, 256, 256, 256, 256, 256};
        send_window(w);
        w = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_window(w);
        idle(6);
        chk("plan_b2b_sum", 32'(bus.o_sum), 32'd0);
        chk("plan_b2b_tot", 32'(bus.o_total), 32'd8);

        // abort after 5 valids, then a window of 3s
        for (int i = 0; i < 5; i++) drive(1'b1, 200);
        idle(1);
        w = '{3, 3, 3, 3, 3, 3, 3, 3};
        send_window(w);
        idle(6);
        chk("plan_abort_sum", 32'(bus.o_sum), 32'd600);

        // reset at the 4th input, then a window of 3s
        for (int i = 0; i < 3; i++) drive(1'b1, 256);
        do_reset(2);
        chk("plan_rst_sum", 32'(bus.o_sum), 32'd0);
        send_window(w);
        idle(6);
        chk("plan_rst_next", 32'(bus.o_sum), 32'd600);

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                k = int'($urandom_range(0, 7));
                for (int i = 0; i < k; i++) drive(1'b1, int'($urandom_range(0, 256)));
                do_reset(int'($urandom_range(1, 3)));
            end else if (r <= 3) begin
                k = int'($urandom_range(1, 7));
                for (int i = 0; i < k; i++) drive(1'b1, int'($urandom_range(0, 256)));
                idle(1);
            end else begin
                for (int i = 0; i < 8; i++) begin
                    case ($urandom_range(0, 9))
                        0:       w[i] = 0;
                        1:       w[i] = 256;
                        2:       w[i] = int'($urandom_range(257, 511));
                        default: w[i] = int'($urandom_range(1, 256));
                    endcase
                end
                send_window(w);
            end
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
